// File: rtl/pipe_pkg.sv
// pipe_pkg: status codes and run-state encoding shared with the PIPE processor
package pipe_pkg;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DONE    = 3'd2,
    ST_FAULT   = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_t;
  function automatic logic stat_ok(input logic [2:0] s);
    return s == STAT_AOK || s == STAT_HLT;
  endfunction
endpackage

// File: rtl/pipe_run_ctrl_sat_counter.sv
// sat_counter: enable-driven up counter with synchronous clear that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (en && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl: reset sequencer, run monitor and end-of-run classifier for the PIPE core
module pipe_run_ctrl
  import pipe_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int CNT_W        = 32,
  parameter int STALL_LIMIT  = 64,
  parameter int HIST_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  input  logic                  retire_W,
  input  logic [2:0]            stat_W,
  input  logic                  cond_f,
  output logic                  cpu_reset,
  output logic [2:0]            run_state,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      retired_count,
  output logic [2:0]            fault_code,
  output logic [HIST_DEPTH-1:0] cond_hist
);
  localparam int HW = $clog2(RESET_CYCLES) + 1;
  // idle compare is done at >=32 bits so a narrow CNT_W cannot alias the limit
  localparam int IW = CNT_W > 32 ? CNT_W : 32;
  run_state_t       state;
  logic [HW-1:0]    hold_cnt;
  logic [CNT_W-1:0] idle_cnt;
  logic             in_run, retire_ok, stall_hit;
  assign in_run    = state == ST_RUN;
  assign retire_ok = in_run && retire_W && stat_ok(stat_W);
  assign stall_hit = STALL_LIMIT != 0 && !retire_W && IW'(idle_cnt) == IW'(STALL_LIMIT - 1);
  assign run_state = state;
  sat_counter #(.W(CNT_W)) u_cycle (
    .clk(clk), .rst_n(reset), .clr(restart), .en(in_run), .q(cycle_count)
  );
  sat_counter #(.W(CNT_W)) u_retired (
    .clk(clk), .rst_n(reset), .clr(restart), .en(retire_ok), .q(retired_count)
  );
  sat_counter #(.W(CNT_W)) u_idle (
    .clk(clk), .rst_n(reset), .clr(restart || retire_ok), .en(in_run && !retire_W), .q(idle_cnt)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= ST_HOLD;
      hold_cnt   <= '0;
      cpu_reset  <= 1'b1;
      fault_code <= '0;
      cond_hist  <= '0;
    end else if (restart) begin
      state      <= ST_HOLD;
      hold_cnt   <= '0;
      cpu_reset  <= 1'b1;
      fault_code <= '0;
      cond_hist  <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HW'(RESET_CYCLES - 1)) begin
            state     <= ST_RUN;
            cpu_reset <= 1'b0;
          end
        end
        ST_RUN:
          if (retire_W) begin
            if (stat_ok(stat_W)) begin
              cond_hist <= HIST_DEPTH'({cond_hist, cond_f});
              if (stat_W == STAT_HLT) state <= ST_DONE;
            end else begin
              fault_code <= stat_W;
              state      <= ST_FAULT;
              cpu_reset  <= 1'b1;
            end
          end else if (stall_hit) begin
            state     <= ST_TIMEOUT;
            cpu_reset <= 1'b1;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_pipe_run_ctrl.sv
// tb_pipe_run_ctrl: directed run-controller scenarios checked against a cycle-level model of the run rules
module tb_pipe_run_ctrl;
  import pipe_pkg::*;
  logic       clk = 0, reset = 0, restart = 0, retire_W = 0, cond_f = 0;
  logic [2:0] stat_W = STAT_AOK;
  logic       cpu_reset, ns_cpu, c4_cpu;
  logic [2:0] run_state, fault_code, ns_state, ns_fc, c4_state, c4_fc;
  logic [31:0] cycle_count, retired_count, ns_cyc, ns_ret;
  logic [3:0] c4_cyc, c4_ret;
  logic [7:0] cond_hist, ns_hist, c4_hist;
  int total = 0, bad = 0, n;

  always #5 clk = ~clk;

  pipe_run_ctrl dut (
    .clk(clk), .reset(reset), .restart(restart), .retire_W(retire_W), .stat_W(stat_W),
    .cond_f(cond_f), .cpu_reset(cpu_reset), .run_state(run_state), .cycle_count(cycle_count),
    .retired_count(retired_count), .fault_code(fault_code), .cond_hist(cond_hist)
  );
  pipe_run_ctrl #(.STALL_LIMIT(0)) dut_ns (
    .clk(clk), .reset(reset), .restart(restart), .retire_W(retire_W), .stat_W(stat_W),
    .cond_f(cond_f), .cpu_reset(ns_cpu), .run_state(ns_state), .cycle_count(ns_cyc),
    .retired_count(ns_ret), .fault_code(ns_fc), .cond_hist(ns_hist)
  );
  pipe_run_ctrl #(.CNT_W(4), .STALL_LIMIT(0)) dut_c4 (
    .clk(clk), .reset(reset), .restart(restart), .retire_W(retire_W), .stat_W(stat_W),
    .cond_f(cond_f), .cpu_reset(c4_cpu), .run_state(c4_state), .cycle_count(c4_cyc),
    .retired_count(c4_ret), .fault_code(c4_fc), .cond_hist(c4_hist)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: phase number, clocks left in hold, plain integer tallies, history as a bit list
  int         m_phase = 0, m_hold_left = 4, m_fc = 0;
  longint     m_cyc = 0, m_ret = 0, m_idle = 0;
  logic [7:0] m_hist = 0;
  logic       m_cpu = 1, m_stall;
  localparam longint MAXC = 64'hFFFF_FFFF;

  always @(posedge clk or negedge reset)
    if (!reset || restart) begin
      m_phase = 0; m_hold_left = 4; m_fc = 0; m_cyc = 0; m_ret = 0; m_idle = 0; m_hist = 0; m_cpu = 1;
    end else if (m_phase == 0) begin
      m_hold_left--;
      if (m_hold_left == 0) begin m_phase = 1; m_cpu = 0; end
    end else if (m_phase == 1) begin
      m_stall = !retire_W && m_idle + 1 == 64;
      if (m_cyc < MAXC) m_cyc++;
      if (retire_W && (stat_W == STAT_AOK || stat_W == STAT_HLT)) begin
        if (m_ret < MAXC) m_ret++;
        m_hist = {m_hist[6:0], cond_f};
        m_idle = 0;
        if (stat_W == STAT_HLT) m_phase = 2;
      end else if (retire_W) begin
        m_fc = stat_W; m_phase = 3; m_cpu = 1;
      end else begin
        if (m_idle < MAXC) m_idle++;
        if (m_stall) begin m_phase = 4; m_cpu = 1; end
      end
    end

  always @(negedge clk)
    if (reset) begin
      chk("m_state", run_state, m_phase);
      chk("m_cpu_reset", cpu_reset, m_cpu);
      chk("m_cycle_count", cycle_count, m_cyc);
      chk("m_retired_count", retired_count, m_ret);
      chk("m_fault_code", fault_code, m_fc);
      chk("m_cond_hist", cond_hist, m_hist);
    end

  task automatic drive(input logic rw, input logic [2:0] st, input logic cf, input logic rs);
    retire_W = rw; stat_W = st; cond_f = cf; restart = rs;
    @(posedge clk); #1;
    retire_W = 0; restart = 0;
  endtask

  task automatic wait_run(output int cnt);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cpu_reset) break;
      cnt++;
    end
  endtask

  initial begin
    // reset sequencing
    @(posedge clk); @(negedge clk);
    chk("rst_state", run_state, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_cycle", cycle_count, 0);
    @(posedge clk); @(posedge clk); #1 reset = 1;
    wait_run(n);
    chk("hold_len", n, 4);
    chk("run_entry", run_state, 1);
    @(posedge clk); #1;
    // ten AOK with alternating cond_f, then HLT
    for (int i = 0; i < 10; i++) drive(1, STAT_AOK, (i % 2 == 0), 0);
    drive(1, STAT_HLT, 1, 0);
    chk("hlt_state", run_state, 2);
    chk("hlt_retired", retired_count, 11);
    chk("hlt_hist", cond_hist, 8'h55);
    chk("hlt_cycles", cycle_count, 12);
    repeat (3) drive(0, STAT_AOK, 0, 0);
    chk("done_frozen_cycles", cycle_count, 12);
    chk("done_cpu_reset", cpu_reset, 0);
    // restart out of DONE
    drive(0, STAT_AOK, 0, 1);
    chk("rs_state", run_state, 0);
    chk("rs_cycle", cycle_count, 0);
    chk("rs_retired", retired_count, 0);
    chk("rs_hist", cond_hist, 0);
    chk("rs_cpu_reset", cpu_reset, 1);
    wait_run(n);
    chk("rs_hold_len", n, 4);
    @(posedge clk); #1;
    // fault after five good retirements
    repeat (5) drive(1, STAT_AOK, 1, 0);
    drive(1, STAT_ADR, 0, 0);
    chk("flt_state", run_state, 3);
    chk("flt_code", fault_code, 3);
    chk("flt_retired", retired_count, 5);
    chk("flt_cpu_reset", cpu_reset, 1);
    repeat (2) drive(1, STAT_AOK, 1, 0);
    chk("flt_held", run_state, 3);
    drive(0, STAT_AOK, 0, 1);
    chk("flt_rs_code", fault_code, 0);
    wait_run(n);
    chk("flt_hold_len", n, 4);
    @(posedge clk); #1;
    // restart beats a simultaneous HLT
    drive(1, STAT_AOK, 1, 0);
    drive(1, STAT_HLT, 1, 1);
    chk("rsh_state", run_state, 0);
    chk("rsh_retired", retired_count, 0);
    chk("rsh_hist", cond_hist, 0);
    wait_run(n);
    chk("rsh_hold_len", n, 4);
    // stall timeout measured from RUN entry
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (run_state == 4) break;
    end
    chk("to_cycles", n, 64);
    chk("to_state", run_state, 4);
    chk("to_code", fault_code, 0);
    chk("to_cpu_reset", cpu_reset, 1);
    repeat (940) @(negedge clk);
    chk("nolimit_state", ns_state, 1);
    chk("c4_sat_long", c4_cyc, 15);
    // asynchronous reset mid-run
    @(posedge clk); #1;
    drive(0, STAT_AOK, 0, 1);
    wait_run(n);
    chk("ar_hold_len", n, 4);
    repeat (20) @(negedge clk);
    chk("ar_cycle20", cycle_count, 20);
    chk("c4_cycle_sat", c4_cyc, 15);
    #2 reset = 0;
    #1;
    chk("ar_state", run_state, 0);
    chk("ar_cpu_reset", cpu_reset, 1);
    chk("ar_cycle", cycle_count, 0);
    chk("ar_retired", retired_count, 0);
    chk("ar_code", fault_code, 0);
    chk("ar_hist", cond_hist, 0);
    chk("ar_c4_cycle", c4_cyc, 0);
    @(posedge clk); #1 reset = 1;
    wait_run(n);
    chk("ar_hold_len2", n, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_run_ctrl.md
Name: pipe_run_ctrl

Overview:
- Synthesizable run controller for the PIPE processor, for FPGA bring-up and regression.
- Replaces hand-timed bench reset pulses with a parametrised reset-hold sequencer.
- Watches the write-back stage for retirement and status, and drives processor reset.
- Counts cycles and retired instructions, keeps a Cond_F history, and classifies how the run ended: halt, fault or stall timeout.

Parameters:
- RESET_CYCLES, 4, cycles cpu_reset stays high after reset release or restart (must be >= 1).
- CNT_W, 32, width of cycle and retire counters.
- STALL_LIMIT, 64, consecutive RUN cycles without retirement before TIMEOUT; 0 disables the timeout.
- HIST_DEPTH, 8, number of Cond_F samples kept (must be >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- restart  in  1  synchronous one-cycle request to rerun the program.
- retire_W  in  1  write-back stage holds a valid (non-bubble) instruction this cycle.
- stat_W  in  3  write-back status code (AOK=1, HLT=2, ADR=3, INS=4).
- cond_f  in  1  processor Cond_F flag.
- cpu_reset  out  1  active-high reset to the processor.
- run_state  out  3  HOLD=0, RUN=1, DONE=2, FAULT=3, TIMEOUT=4.
- cycle_count  out  CNT_W  cycles spent in RUN.
- retired_count  out  CNT_W  instructions retired with status AOK or HLT.
- fault_code  out  3  stat_W captured on fault; 0 otherwise.
- cond_hist  out  HIST_DEPTH  Cond_F samples at retirement; bit 0 is newest.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous): state=HOLD, hold_cnt=0, cpu_reset=1, cycle_count=0, retired_count=0, idle_cnt=0, fault_code=0, cond_hist=0.
- HOLD:
  - cpu_reset=1; hold_cnt increments each cycle.
  - When hold_cnt==RESET_CYCLES-1, the next state is RUN and cpu_reset goes to 0 on the same edge.
  - Result: cpu_reset is high for exactly RESET_CYCLES clocks after reset rises.
  - Counters and inputs are ignored.
- RUN:
  - cycle_count increments every cycle, saturating at all-ones.
  - On retire_W=1, stat_W selects the action:
    - AOK: retired_count++ (saturating), cond_hist <= {cond_hist[HIST_DEPTH-2:0], cond_f}, idle_cnt=0.
    - HLT: same updates as AOK, then the next state is DONE.
    - ADR, INS or any other code: fault_code<=stat_W, next state FAULT; retired_count and cond_hist are not updated.
  - On retire_W=0: idle_cnt++ (saturating).
  - If STALL_LIMIT!=0 and idle_cnt reaches STALL_LIMIT-1 while retire_W=0, the next state is TIMEOUT.
  - Priority within a cycle: restart > stat classification > timeout.
- DONE: cpu_reset=0; all counters and cond_hist frozen.
- FAULT and TIMEOUT: cpu_reset=1 to freeze the processor; counters frozen; fault_code held (0 in TIMEOUT).
- restart=1 in any state:
  - Next state HOLD; hold_cnt, cycle_count, retired_count, idle_cnt, fault_code and cond_hist cleared; cpu_reset=1 the next cycle.
  - restart during HOLD restarts the hold count.
- reset asserted mid-run: immediate return to the reset values, independent of clk.
- HIST_DEPTH==1: cond_hist holds only the latest sample.

Decomposition:
- Shared package pipe_pkg:
  - stat codes STAT_AOK/HLT/ADR/INS (3 bits).
  - run_state encoding typedef run_state_t.
  - The processor uses the same stat constants.
- One natural sub-module: sat_counter, a parametrised width, enable, synchronous clear and saturate-at-max counter.
  - Instantiated for cycle_count, retired_count and idle_cnt.
- The FSM and history register stay in pipe_run_ctrl.

Test Plan:
1. Defaults, reset low 3 cycles then high; inputs idle.
   - cpu_reset=1 for exactly 4 rising edges after release, then 0; run_state 0→1.
2. In RUN, 10 retirements with stat=AOK, cond_f alternating 1,0,…, then one with stat=HLT and cond_f=1.
   - run_state=2, retired_count=11, cond_hist=8'b0101_0101 (newest 1 in bit 0), cycle_count frozen.
3. In RUN, retire with stat=ADR after 5 AOK retirements.
   - run_state=3, fault_code=3, retired_count=5, cpu_reset=1.
4. STALL_LIMIT=64, retire_W held 0 in RUN.
   - run_state=4 exactly 64 cycles after RUN entry, fault_code=0; with STALL_LIMIT=0, no TIMEOUT after 1000 cycles.
5. restart pulse in DONE, and same cycle as HLT retirement.
   - Both go to HOLD with counters=0 and cond_hist=0; restart wins over HLT; cpu_reset high 4 cycles again.
6. reset pulled low asynchronously mid-RUN with cycle_count=20.
   - Outputs return to reset values before the next clk edge; CNT_W=4 run of 20 cycles shows cycle_count saturated at 15.
